// File: rtl/polar_dec_pkg.sv
// rtl/polar_dec_pkg.sv - shared constants, state type and layer base helper for the polar decoder
package polar_dec_pkg;

   localparam int ID_W    = 10;
   localparam int LAYER_W = 4;
   localparam int ADDR_W  = ID_W + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   // Tree memory stores layer l in the top 2**(l+1) words; the root layer wraps to address 0.
   function automatic logic [ADDR_W-1:0] layer_base(input logic [LAYER_W-1:0] l);
      logic [ADDR_W:0] span;
      logic [ADDR_W:0] neg;
      span = (ADDR_W+1)'(1) << ({1'b0, l} + (LAYER_W+1)'(1));
      neg  = (ADDR_W+1)'(0) - span;
      return neg[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/trailing_ones_enc.sv
// rtl/trailing_ones_enc.sv - combinational count of trailing ones of a bit index
import polar_dec_pkg::*;

module trailing_ones_enc #(
   parameter int IN_W  = ID_W,
   parameter int OUT_W = LAYER_W
) (
   input  logic [IN_W-1:0]  id,
   output logic [OUT_W-1:0] ones
);

   logic run;

   always_comb begin
      ones = '0;
      run  = 1'b1;
      for (int i = 0; i < IN_W; i++) begin
         if (run && id[i]) begin
            ones = ones + OUT_W'(1);
         end else begin
            run = 1'b0;
         end
      end
   end

endmodule

// File: rtl/psum_update_seq.sv
// rtl/psum_update_seq.sv - partial-sum update sequencer issuing one merge command per layer
import polar_dec_pkg::*;

module psum_update_seq (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ID_W-1:0]    in_id,
   input  logic               in_bit,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [LAYER_W-1:0] cmd_layer,
   output logic [ADDR_W-1:0]  cmd_base,
   output logic [ID_W:0]      cmd_len,
   output logic               cmd_bit,
   output logic               cmd_last,
   output logic               upd_done,
   output logic               frame_done
);

   state_t             state;
   logic [LAYER_W-1:0] end_layer;
   logic               id_is_last;
   logic [LAYER_W-1:0] in_ones;
   logic [LAYER_W-1:0] next_layer;

   trailing_ones_enc #(.IN_W(ID_W), .OUT_W(LAYER_W)) u_ones (
      .id   (in_id),
      .ones (in_ones)
   );

   assign next_layer = cmd_layer + LAYER_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         end_layer  <= '0;
         id_is_last <= 1'b0;
         in_ready   <= 1'b1;
         cmd_valid  <= 1'b0;
         cmd_layer  <= '0;
         cmd_base   <= '0;
         cmd_len    <= '0;
         cmd_bit    <= 1'b0;
         cmd_last   <= 1'b0;
         upd_done   <= 1'b0;
         frame_done <= 1'b0;
      end else if (flush) begin
         // Abort wins over any handshake in the same cycle and leaves no done pulse behind.
         state      <= IDLE;
         end_layer  <= '0;
         id_is_last <= 1'b0;
         in_ready   <= 1'b1;
         cmd_valid  <= 1'b0;
         cmd_layer  <= '0;
         cmd_base   <= '0;
         cmd_len    <= '0;
         cmd_bit    <= 1'b0;
         cmd_last   <= 1'b0;
         upd_done   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         upd_done   <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state      <= ISSUE;
                  end_layer  <= in_ones;
                  id_is_last <= (in_id == '1);
                  in_ready   <= 1'b0;
                  cmd_valid  <= 1'b1;
                  cmd_layer  <= '0;
                  cmd_base   <= layer_base('0);
                  cmd_len    <= (ID_W+1)'(1);
                  cmd_bit    <= in_bit;
                  cmd_last   <= (in_ones == '0);
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  if (cmd_last) begin
                     state      <= IDLE;
                     in_ready   <= 1'b1;
                     cmd_valid  <= 1'b0;
                     cmd_layer  <= '0;
                     cmd_base   <= '0;
                     cmd_len    <= '0;
                     cmd_bit    <= 1'b0;
                     cmd_last   <= 1'b0;
                     upd_done   <= 1'b1;
                     frame_done <= id_is_last;
                  end else begin
                     cmd_layer <= next_layer;
                     cmd_base  <= layer_base(next_layer);
                     cmd_len   <= {cmd_len[ID_W-1:0], 1'b0};
                     cmd_last  <= (next_layer == end_layer);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_update_seq.sv
// tb/tb_psum_update_seq.sv - self-checking randomized bench for psum_update_seq
module tb_psum_update_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [9:0]  in_id;
   logic        in_bit;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_layer;
   logic [10:0] cmd_base;
   logic [10:0] cmd_len;
   logic        cmd_bit;
   logic        cmd_last;
   logic        upd_done;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   localparam int NO_ABORT = 99;
   localparam int AB_FLUSH = 1;
   localparam int AB_RESET = 2;

   psum_update_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_id      (in_id),
      .in_bit     (in_bit),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_layer  (cmd_layer),
      .cmd_base   (cmd_base),
      .cmd_len    (cmd_len),
      .cmd_bit    (cmd_bit),
      .cmd_last   (cmd_last),
      .upd_done   (upd_done),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_trailing_ones(input int id);
      int n = 0;
      while ((id & 1) == 1 && n < 10) begin
         n++;
         id = id >> 1;
      end
      return n;
   endfunction

   function automatic int ref_base(input int l);
      return (2048 - (1 << (l + 1))) % 2048;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},   in_ready,   1);
      check({tag, "_cmd_valid"},  cmd_valid,  0);
      check({tag, "_cmd_layer"},  cmd_layer,  0);
      check({tag, "_cmd_base"},   cmd_base,   0);
      check({tag, "_cmd_len"},    cmd_len,    0);
      check({tag, "_cmd_bit"},    cmd_bit,    0);
      check({tag, "_cmd_last"},   cmd_last,   0);
      check({tag, "_upd_done"},   upd_done,   0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   // One full update: accept id, walk the expected layers, optionally stall one layer or abort at one.
   task automatic do_update(input int id, input logic b, input int stall_layer, input int stall_cnt,
                            input bit rnd, input int abort_layer, input int abort_kind);
      int el;
      int st;
      el = ref_trailing_ones(id);
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_cmd_valid", cmd_valid, 0);
      check("idle_upd_done", upd_done, 0);
      in_valid = 1'b1;
      in_id    = 10'(id);
      in_bit   = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_id    = 10'($urandom);
      in_bit   = 1'($urandom);
      for (int l = 0; l <= el; l++) begin
         st = (l == stall_layer) ? stall_cnt : (rnd ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s <= st; s++) begin
            @(negedge clk);
            check("cmd_valid", cmd_valid, 1);
            check("cmd_layer", cmd_layer, l);
            check("cmd_base", cmd_base, ref_base(l));
            check("cmd_len", cmd_len, 1 << l);
            if (l == 0) check("cmd_bit", cmd_bit, b);
            check("cmd_last", cmd_last, (l == el) ? 1 : 0);
            check("busy_in_ready", in_ready, 0);
            check("busy_upd_done", upd_done, 0);
            check("busy_frame_done", frame_done, 0);
            if (l == abort_layer && s == st) begin
               cmd_ready = 1'b1;
               if (abort_kind == AB_FLUSH) begin
                  flush = 1'b1;
                  @(posedge clk);
                  #1;
                  flush     = 1'b0;
                  cmd_ready = 1'b0;
                  @(negedge clk);
                  check_reset_values("flush");
               end else begin
                  #2;
                  rst_n = 1'b0;
                  #1;
                  check_reset_values("async_rst");
                  @(negedge clk);
                  cmd_ready = 1'b0;
                  rst_n     = 1'b1;
               end
               return;
            end
            cmd_ready = (s == st);
         end
         @(posedge clk);
         #1;
         cmd_ready = 1'b0;
      end
      @(negedge clk);
      check("done_upd_done", upd_done, 1);
      check("done_frame_done", frame_done, (id == 1023) ? 1 : 0);
      check("done_cmd_valid", cmd_valid, 0);
      check("done_in_ready", in_ready, 1);
   endtask

   initial begin
      int id;
      int k;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_id     = '0;
      in_bit    = 1'b0;
      cmd_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      do_update(10'h000, 1'b1, -1, 0, 1'b0, NO_ABORT, 0);
      do_update(10'h003, 1'b0, -1, 0, 1'b0, NO_ABORT, 0);
      do_update(10'h3FF, 1'b1, -1, 0, 1'b0, NO_ABORT, 0);
      do_update(10'h007, 1'b1, 1, 3, 1'b0, NO_ABORT, 0);
      do_update(10'h00F, 1'b0, -1, 0, 1'b0, 2, AB_FLUSH);
      do_update(10'h002, 1'b1, -1, 0, 1'b0, NO_ABORT, 0);
      do_update(10'h3FF, 1'b0, -1, 0, 1'b0, 3, AB_RESET);
      @(negedge clk);
      check_reset_values("post_rst");
      do_update(10'h001, 1'b1, -1, 0, 1'b0, NO_ABORT, 0);

      for (int n = 0; n < 40; n++) begin
         k  = $urandom_range(0, 10);
         id = ($urandom & 1023) | ((1 << k) - 1);
         if (k < 10) id = id & ~(1 << k);
         do_update(id, 1'($urandom), -1, 0, 1'b1, NO_ABORT, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
